// File: rtl/vt512_pkg.sv
// Shared definitions for the 512-wide padded image memory blocks.
//   DATA_WIDTH_DEF          : default pixel width in bits
//   MAX_IMAGE_SIZE_DEF      : default padded memory side length
//   MAX_IMAGE_SIZE_LOG2_DEF : default log2 of the side length
//   loader_state_e          : pixel_stream_loader FSM states, in visiting order
package vt512_pkg;

    localparam int DATA_WIDTH_DEF          = 8;
    localparam int MAX_IMAGE_SIZE_DEF      = 512;
    localparam int MAX_IMAGE_SIZE_LOG2_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAD_TOP,
        ST_PAD_SIDES,
        ST_LOAD,
        ST_PAD_BOTTOM,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/pixel_stream_loader.sv
// Loads a raster pixel stream into a zero-padded single-channel memory.
// The frame of W x H pixels lands at rows/cols 1..H / 1..W; a one-pixel
// zero border is written around it (row 0, row H+1, col 0, col W+1).
//   clk, rst_n              : clock, async active-low reset
//   start, img_width/height : frame request, sizes sampled in IDLE
//   s_valid, s_data, s_ready: pixel stream handshake (ready only in LOAD)
//   mem_we/row/col/data     : registered memory write port
//   busy, done, size_err    : status; done and size_err are one-cycle pulses
module pixel_stream_loader
    import vt512_pkg::*;
#(
    parameter int DATA_WIDTH          = DATA_WIDTH_DEF,
    parameter int MAX_IMAGE_SIZE      = MAX_IMAGE_SIZE_DEF,
    parameter int MAX_IMAGE_SIZE_LOG2 = MAX_IMAGE_SIZE_LOG2_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [MAX_IMAGE_SIZE_LOG2:0] img_width,
    input  logic [MAX_IMAGE_SIZE_LOG2:0] img_height,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         mem_we,
    output logic [MAX_IMAGE_SIZE_LOG2:0] mem_row,
    output logic [MAX_IMAGE_SIZE_LOG2:0] mem_col,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         busy,
    output logic                         done,
    output logic                         size_err
);

    localparam int AW = MAX_IMAGE_SIZE_LOG2 + 1;
    typedef logic [AW-1:0] idx_t;

    // Largest frame side that still leaves room for both border cells.
    localparam idx_t MAX_DIM = idx_t'(MAX_IMAGE_SIZE - 2);
    localparam idx_t ONE     = idx_t'(1);

    loader_state_e         state_q, state_d;
    idx_t                  w_q, w_d, h_q, h_d;
    idx_t                  row_q, row_d, col_q, col_d;
    logic                  side_q, side_d;   // PAD_SIDES: 0 = left cell, 1 = right cell
    logic                  we_q, we_d;
    idx_t                  mrow_q, mrow_d, mcol_q, mcol_d;
    logic [DATA_WIDTH-1:0] mdat_q, mdat_d;
    logic                  done_q, done_d, err_q, err_d;

    logic size_ok;
    idx_t wp1;

    assign size_ok = (img_width  != '0) && (img_width  <= MAX_DIM) &&
                     (img_height != '0) && (img_height <= MAX_DIM);
    assign wp1     = w_q + ONE;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        row_d   = row_q;
        col_d   = col_q;
        side_d  = side_q;
        we_d    = 1'b0;
        mrow_d  = mrow_q;
        mcol_d  = mcol_q;
        mdat_d  = mdat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        state_d = ST_PAD_TOP;
                        w_d     = img_width;
                        h_d     = img_height;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PAD_TOP, ST_PAD_BOTTOM: begin
                we_d   = 1'b1;
                mrow_d = row_q;
                mcol_d = col_q;
                mdat_d = '0;
                if (col_q == wp1) begin
                    if (state_q == ST_PAD_TOP) begin
                        state_d = ST_PAD_SIDES;
                        row_d   = ONE;
                        side_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    col_d = col_q + ONE;
                end
            end
            ST_PAD_SIDES: begin
                we_d   = 1'b1;
                mrow_d = row_q;
                mcol_d = side_q ? wp1 : '0;
                mdat_d = '0;
                side_d = ~side_q;
                if (side_q) begin
                    if (row_q == h_q) begin
                        state_d = ST_LOAD;
                        row_d   = ONE;
                        col_d   = ONE;
                    end else begin
                        row_d = row_q + ONE;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    we_d   = 1'b1;
                    mrow_d = row_q;
                    mcol_d = col_q;
                    mdat_d = s_data;
                    if (col_q == w_q) begin
                        col_d = ONE;
                        if (row_q == h_q) begin
                            // Bottom border restarts at col 0.
                            state_d = ST_PAD_BOTTOM;
                            row_d   = h_q + ONE;
                            col_d   = '0;
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            ST_DONE: begin
                // DONE is entered the cycle the last write is presented,
                // so the registered pulse lands one cycle later.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            side_q  <= 1'b0;
            we_q    <= 1'b0;
            mrow_q  <= '0;
            mcol_q  <= '0;
            mdat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            row_q   <= row_d;
            col_q   <= col_d;
            side_q  <= side_d;
            we_q    <= we_d;
            mrow_q  <= mrow_d;
            mcol_q  <= mcol_d;
            mdat_q  <= mdat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s_ready  = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign mem_we   = we_q;
    assign mem_row  = mrow_q;
    assign mem_col  = mcol_q;
    assign mem_data = mdat_q;
    assign done     = done_q;
    assign size_err = err_q;

endmodule

// File: tb/tb_pixel_stream_loader.sv
`timescale 1ns/1ps
module tb_pixel_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] img_width = '0;
    logic [9:0] img_height = '0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, mem_we, busy, done, size_err;
    logic [9:0] mem_row, mem_col;
    logic [7:0] mem_data;

    pixel_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .img_width(img_width), .img_height(img_height),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_row(mem_row), .mem_col(mem_col), .mem_data(mem_data),
        .busy(busy), .done(done), .size_err(size_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_we_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented write must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_t e;
            last_we_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%0h expected no write",
                         mem_row, mem_col, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_row != e.row || mem_col != e.col || mem_data != e.data) begin
                    failures++;
                    $display("FAIL write: got (%0d,%0d)=%0h expected (%0d,%0d)=%0h",
                             mem_row, mem_col, mem_data, e.row, e.col, e.data);
                end
            end
        end
    end

    function automatic logic [7:0] pixval(input int k);
        return 8'((k + 1) * 8'h11);
    endfunction

    function automatic wr_t mk(input int r, input int c, input logic [7:0] d);
        wr_t t;
        t.row = 10'(r); t.col = 10'(c); t.data = d;
        return t;
    endfunction

    task automatic push_frame(input int w, input int h);
        for (int c = 0; c <= w + 1; c++) exp_q.push_back(mk(0, c, 8'h00));
        for (int r = 1; r <= h; r++) begin
            exp_q.push_back(mk(r, 0, 8'h00));
            exp_q.push_back(mk(r, w + 1, 8'h00));
        end
        for (int k = 0; k < w * h; k++) exp_q.push_back(mk(k / w + 1, k % w + 1, pixval(k)));
        for (int c = 0; c <= w + 1; c++) exp_q.push_back(mk(h + 1, c, 8'h00));
    endtask

    // Issue start on a negedge; returns at the first PAD_TOP negedge.
    task automatic issue_start(input int w, input int h);
        @(negedge clk);
        start = 1'b1; img_width = 10'(w); img_height = 10'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit gap, input bit poke);
        int k = 0, guard = 0, waitcnt = 0, start_cyc;
        bit seen_ready = 0, valid;
        int budget = 2 * w * h + 4 * (w + h) + 50;
        push_frame(w, h);
        issue_start(w, h);
        start_cyc = cyc;
        chk("busy_in_frame", busy, 1);
        while (k < w * h && guard < budget) begin
            start = poke && (guard == w + 3);  // lands inside PAD_SIDES
            valid = gap ? (guard % 2 == 0) : 1'b1;
            s_valid = valid;
            s_data = pixval(k);
            if (s_ready) seen_ready = 1;
            if (!seen_ready) waitcnt++;
            if (s_ready && valid) k++;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0; start = 1'b0;
        chk("load_beats", k, w * h);
        chk("pad_cycles_before_ready", waitcnt, w + 2 + 2 * h);
        chk("ready_after_load", s_ready, 0);
        for (int i = 0; i < w + 20 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1);
        chk("done_after_last_write", cyc - last_we_cyc, 1);
        if (!gap) chk("frame_cycles", cyc - start_cyc, 2 * (w + 2) + 2 * h + w * h + 1);
        chk("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_pulse", done, 0);
        chk("busy_after_done", busy, 0);
        exp_q.delete();
    endtask

    task automatic size_err_case(input int w, input int h);
        issue_start(w, h);
        chk("size_err_pulse", size_err, 1);
        chk("size_err_busy", busy, 0);
        chk("size_err_we", mem_we, 0);
        @(negedge clk);
        chk("size_err_clears", size_err, 0);
        chk("size_err_idle", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_size_err"}, size_err, 0);
        chk({tag, "_mem_row"}, mem_row, 0);
        chk({tag, "_mem_col"}, mem_col, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(2, 2, 0, 0);      // 2x2 directed pixels 11,22,33,44
        run_frame(3, 1, 1, 0);      // s_valid toggling
        size_err_case(0, 2);
        size_err_case(511, 2);
        size_err_case(4, 0);
        run_frame(510, 2, 0, 0);    // widest frame: cols up to 511
        run_frame(2, 510, 0, 0);    // tallest frame: rows up to 511
        run_frame(4, 3, 0, 1);      // start poked during PAD_SIDES

        // Reset after 5 LOAD beats abandons the frame.
        begin
            int k = 0, guard = 0;
            push_frame(4, 3);
            issue_start(4, 3);
            while (k < 5 && guard < 100) begin
                s_valid = 1'b1;
                s_data = pixval(k);
                if (s_ready) k++;
                @(negedge clk);
                guard++;
            end
            s_valid = 1'b0;
            chk("beats_before_reset", k, 5);
            #2 rst_n = 1'b0;
            #1 check_all_zero("mid_reset");
            exp_q.delete();
            @(negedge clk);
            check_all_zero("mid_reset_next");
            #2 rst_n = 1'b1;
            repeat (4) @(negedge clk);
            chk("idle_after_reset", busy, 0);
        end
        run_frame(4, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
